// File: rtl/am2940_dma_sequencer_pkg.sv
// Shared definitions for the am2940 DMA sequencer: am2940 instruction codes and FSM states.
package am2940_dma_sequencer_pkg;

   // am2940 instruction codes
   typedef enum logic [2:0] {
      InstrWrCr   = 3'b000,
      InstrRdCr   = 3'b001,
      InstrRdWc   = 3'b010,
      InstrRdAc   = 3'b011,
      InstrReinit = 3'b100,
      InstrLdAc   = 3'b101,
      InstrLdWc   = 3'b110,
      InstrEnable = 3'b111
   } am2940_instr_e;

   // Sequencer states
   typedef enum logic [2:0] {
      StIdle,
      StWcr,
      StLwc,
      StLac,
      StReq,
      StStep,
      StChk,
      StFin
   } seq_state_e;

   localparam int unsigned CrW = 3;

   // States in which am2940 is enabled and drives the memory address
   function automatic logic is_enable_phase(input seq_state_e s);
      return s inside {StReq, StStep, StChk};
   endfunction

endpackage

// File: rtl/am2940_dma_sequencer_if.sv
// Request, am2940 programming and memory handshake signals of the DMA sequencer.
interface am2940_dma_sequencer_if #(
   parameter int unsigned AW = 8
);
   // Request side
   logic          start;
   logic [2:0]    cr_in;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] word_cnt;
   logic          abort;
   logic          busy;
   logic          xfer_done;
   logic          err;
   logic [AW-1:0] beats;
   // am2940 side
   logic [2:0]    instr;
   logic [AW-1:0] data;
   logic          oeaddr;
   logic          aci;
   logic          wci;
   logic          done;
   // Memory handshake
   logic          mem_req;
   logic          mem_ack;

   // Sequencer view
   modport master (
      input  start, cr_in, base_addr, word_cnt, abort, done, mem_ack,
      output busy, xfer_done, err, beats, instr, data, oeaddr, aci, wci, mem_req
   );

   // Environment view (request logic, am2940, memory)
   modport slave (
      output start, cr_in, base_addr, word_cnt, abort, done, mem_ack,
      input  busy, xfer_done, err, beats, instr, data, oeaddr, aci, wci, mem_req
   );
endinterface

// File: rtl/am2940_dma_sequencer_timeout_ctr.sv
// Memory-acknowledge timeout counter; tc_o flags a count of ACK_TMO-1.
module am2940_dma_sequencer_timeout_ctr #(
   parameter int unsigned ACK_TMO = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int unsigned CW = (ACK_TMO > 2) ? $clog2(ACK_TMO) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == CW'(ACK_TMO - 1));

   // Next count: clear wins, saturate at terminal count
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/am2940_dma_sequencer.sv
// Upstream controller for am2940: programs CR/WC/AC, then steps one word per memory handshake.
module am2940_dma_sequencer
   import am2940_dma_sequencer_pkg::*;
#(
   parameter int unsigned AW      = 8,
   parameter int unsigned ACK_TMO = 16
) (
   input logic                    clk,
   input logic                    rst,
   am2940_dma_sequencer_if.master bus
);

   seq_state_e    state_q, state_d;
   logic          fin_err;
   logic [CrW-1:0] cr_q;
   logic [AW-1:0] wc_q, base_q, beats_q;
   logic          busy_q, xfer_done_q, err_q;
   logic          tmo_tc;

   am2940_instr_e instr_c;
   logic [AW-1:0] data_c;
   logic          cnt_en_n;

   // Counter is held clear outside REQ so every REQ visit starts from zero
   am2940_dma_sequencer_timeout_ctr #(
      .ACK_TMO (ACK_TMO)
   ) u_timeout_ctr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (state_q != StReq),
      .en_i  (state_q == StReq),
      .tc_o  (tmo_tc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort overrides everything outside IDLE/FIN
   always_comb begin
      state_d = state_q;
      fin_err = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = (bus.word_cnt == '0) ? StFin : StWcr;
            end
         end
         StWcr: state_d = StLwc;
         StLwc: state_d = StLac;
         StLac: state_d = StReq;
         StReq: begin
            if (bus.mem_ack) begin
               state_d = StStep;
            end else if (tmo_tc) begin
               state_d = StFin;
               fin_err = 1'b1;
            end
         end
         StStep: state_d = StChk;
         StChk:  state_d = bus.done ? StFin : StReq;
         StFin:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (bus.abort && !(state_q inside {StIdle, StFin})) begin
         state_d = StFin;
         fin_err = 1'b1;
      end
   end

   // Moore outputs decoded from state only: no path from mem_ack to aci/wci
   always_comb begin
      instr_c  = InstrRdCr;
      data_c   = '0;
      unique case (state_q)
         StWcr: begin
            instr_c = InstrWrCr;
            data_c  = AW'(cr_q);
         end
         StLwc: begin
            instr_c = InstrLdWc;
            data_c  = wc_q;
         end
         StLac: begin
            instr_c = InstrLdAc;
            data_c  = base_q;
         end
         StReq, StStep, StChk: instr_c = InstrEnable;
         default: instr_c = InstrRdCr;
      endcase
      cnt_en_n = (state_q != StStep);
   end

   // Request latch, beat counter and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         cr_q        <= '0;
         wc_q        <= '0;
         base_q      <= '0;
         beats_q     <= '0;
         busy_q      <= 1'b0;
         xfer_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (state_q == StIdle && bus.start) begin
            cr_q    <= bus.cr_in;
            wc_q    <= bus.word_cnt;
            base_q  <= bus.base_addr;
            beats_q <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
         end
         if (state_q == StStep) begin
            beats_q <= beats_q + AW'(1);
         end
         if (state_q == StFin) begin
            busy_q <= 1'b0;
         end
         if (fin_err) begin
            err_q <= 1'b1;
         end
         xfer_done_q <= (state_q == StFin);
      end
   end

   assign bus.instr     = instr_c;
   assign bus.data      = data_c;
   assign bus.oeaddr    = !is_enable_phase(state_q);
   assign bus.aci       = cnt_en_n;
   assign bus.wci       = cnt_en_n;
   assign bus.mem_req   = (state_q == StReq);
   assign bus.busy      = busy_q;
   assign bus.xfer_done = xfer_done_q;
   assign bus.err       = err_q;
   assign bus.beats     = beats_q;

endmodule
